cdb_arbiter: RTL and testbench

//   Producer end of the common data bus. Collects completed results (tag, data)

---
 rtl/cdb_arbiter.sv | 152 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus producer: per-source result FIFOs, round-robin pick of one
// stored result per cycle, registered broadcast word that never carries tag 0.
module cdb_arbiter #(
    parameter int N_SRC = 5,
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [N_SRC-1:0]         src_valid,
    output logic [N_SRC-1:0]         src_ready,
    input  logic [N_SRC*TAG_W-1:0]   src_tag,
    input  logic [N_SRC*32-1:0]      src_data,
    output logic [TAG_W+32:0]        cdb,
    output logic [N_SRC-1:0]         cdb_grant,
    output logic                     tag_zero_err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CDB_W = 1 + TAG_W + 32;

    logic [CNT_W-1:0] r_count    [N_SRC];
    logic [PTR_W-1:0] r_wptr     [N_SRC];
    logic [PTR_W-1:0] r_rptr     [N_SRC];
    logic [TAG_W-1:0] r_tag_mem  [N_SRC][DEPTH];
    logic [31:0]      r_data_mem [N_SRC][DEPTH];
    logic [IDX_W-1:0] r_rr_last;
    logic [CDB_W-1:0] r_cdb;
    logic [N_SRC-1:0] r_grant;
    logic             r_tag_zero_err;

    logic [N_SRC-1:0] w_ready;
    logic [N_SRC-1:0] w_elig;
    logic [N_SRC-1:0] w_zero_hit;
    logic [N_SRC-1:0] w_push;
    logic [N_SRC-1:0] w_pop;
    logic             w_found;
    logic [IDX_W-1:0] w_win;
    logic [TAG_W-1:0] w_head_tag;
    logic [31:0]      w_head_data;

    // Per-source acceptance, eligibility and push qualification
    always_comb begin
        w_ready    = {N_SRC{1'b0}};
        w_elig     = {N_SRC{1'b0}};
        w_zero_hit = {N_SRC{1'b0}};
        w_push     = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            w_ready[i]    = (r_count[i] < CNT_W'(DEPTH));
            w_elig[i]     = (r_count[i] != {CNT_W{1'b0}});
            // A zero tag is flagged but never enters the buffer
            w_zero_hit[i] = src_valid[i] & w_ready[i] & ~flush &
                            (src_tag[i*TAG_W +: TAG_W] == {TAG_W{1'b0}});
            w_push[i]     = src_valid[i] & w_ready[i] & ~flush & ~w_zero_hit[i];
        end
    end

    // Round-robin scan starting just after the last granted source
    always_comb begin
        int v;
        w_found = 1'b0;
        w_win   = {IDX_W{1'b0}};
        v       = 0;
        for (int k = 1; k <= N_SRC; k++) begin
            v = (int'(r_rr_last) + k) % N_SRC;
            if (w_found) begin
            end else if (w_elig[v]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(v);
            end else begin
            end
        end
    end

    // Pop selection and head-of-winner read
    always_comb begin
        w_pop = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            w_pop[i] = w_found & ~flush & (w_win == IDX_W'(i));
        end
        w_head_tag  = r_tag_mem[w_win][r_rptr[w_win]];
        w_head_data = r_data_mem[w_win][r_rptr[w_win]];
    end

    // Buffer occupancy and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                r_count[i] <= {CNT_W{1'b0}};
                r_wptr[i]  <= {PTR_W{1'b0}};
                r_rptr[i]  <= {PTR_W{1'b0}};
            end
        end else if (flush) begin
            for (int i = 0; i < N_SRC; i++) begin
                r_count[i] <= {CNT_W{1'b0}};
                r_wptr[i]  <= {PTR_W{1'b0}};
                r_rptr[i]  <= {PTR_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + PTR_W'(1);
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PTR_W'(1);
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
                    2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // Result storage; contents are don't-care while a slot is empty
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (w_push[i]) begin
                r_tag_mem[i][r_wptr[i]]  <= src_tag[i*TAG_W +: TAG_W];
                r_data_mem[i][r_wptr[i]] <= src_data[i*32 +: 32];
            end
        end
    end

    // Broadcast word, grant, round-robin pointer and sticky tag-0 flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cdb          <= {CDB_W{1'b0}};
            r_grant        <= {N_SRC{1'b0}};
            r_rr_last      <= IDX_W'(N_SRC - 1);
            r_tag_zero_err <= 1'b0;
        end else begin
            if (|w_zero_hit) r_tag_zero_err <= 1'b1;
            if (flush) begin
                r_cdb   <= {CDB_W{1'b0}};
                r_grant <= {N_SRC{1'b0}};
            end else if (w_found) begin
                r_cdb     <= {1'b1, w_head_tag, w_head_data};
                r_grant   <= N_SRC'(1) << w_win;
                r_rr_last <= w_win;
            end else begin
                r_cdb   <= {CDB_W{1'b0}};
                r_grant <= {N_SRC{1'b0}};
            end
        end
    end

    assign src_ready    = w_ready;
    assign cdb          = r_cdb;
    assign cdb_grant    = r_grant;
    assign tag_zero_err = r_tag_zero_err;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-computed grants, cdb words, ready and
// error flags across single, contention, fairness, backpressure, tag-0 and flush/reset steps.
module tb_cdb_arbiter;
    logic         clk;
    logic         rst;
    logic         flush;
    logic [4:0]   src_valid;
    logic [4:0]   src_ready;
    logic [24:0]  src_tag;
    logic [159:0] src_data;
    logic [37:0]  cdb;
    logic [4:0]   cdb_grant;
    logic         tag_zero_err;

    int checks   = 0;
    int failures = 0;

    cdb_arbiter #(.N_SRC(5), .TAG_W(5), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_tag(src_tag), .src_data(src_data),
        .cdb(cdb), .cdb_grant(cdb_grant), .tag_zero_err(tag_zero_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [37:0] word(input logic [4:0] tag, input logic [31:0] data);
        return {1'b1, tag, data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        src_valid = 5'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        #3;
        rst       = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; src_valid = 5'b0; src_tag = 25'b0; src_data = 160'b0;
        #2;
        chk("rst_cdb",   64'(cdb), 64'h0);
        chk("rst_grant", 64'(cdb_grant), 64'h0);
        chk("rst_err",   64'(tag_zero_err), 64'h0);
        chk("rst_ready", 64'(src_ready), 64'h1f);
        tick();
        rst = 1'b0;

        // Single result from source 2
        src_valid = 5'b00100; src_tag[10 +: 5] = 5'd7; src_data[64 +: 32] = 32'hDEADBEEF;
        tick();
        src_valid = 5'b0;
        chk("single_lat_cdb", 64'(cdb), 64'h0);
        tick();
        chk("single_cdb",   64'(cdb), 64'(word(5'd7, 32'hDEADBEEF)));
        chk("single_grant", 64'(cdb_grant), 64'h04);
        tick();
        chk("single_idle_cdb",   64'(cdb), 64'h0);
        chk("single_idle_grant", 64'(cdb_grant), 64'h0);

        // Contention: sources 0,1,3 from reset priority
        do_reset();
        src_valid = 5'b01011;
        src_tag[0 +: 5]  = 5'd1; src_data[0 +: 32]  = 32'h100;
        src_tag[5 +: 5]  = 5'd2; src_data[32 +: 32] = 32'h101;
        src_tag[15 +: 5] = 5'd3; src_data[96 +: 32] = 32'h103;
        tick();
        src_valid = 5'b0;
        tick();
        chk("cont_g0", 64'(cdb_grant), 64'h01);
        chk("cont_c0", 64'(cdb), 64'(word(5'd1, 32'h100)));
        tick();
        chk("cont_g1", 64'(cdb_grant), 64'h02);
        chk("cont_c1", 64'(cdb), 64'(word(5'd2, 32'h101)));
        tick();
        chk("cont_g3", 64'(cdb_grant), 64'h08);
        chk("cont_c3", 64'(cdb), 64'(word(5'd3, 32'h103)));
        tick();
        chk("cont_idle", 64'(cdb_grant), 64'h0);

        // Fairness: 0 and 4 continuous; last grant was 3 so 4 leads
        src_valid = 5'b10001;
        src_tag[0 +: 5]  = 5'd10; src_data[0 +: 32]   = 32'hA0;
        src_tag[20 +: 5] = 5'd14; src_data[128 +: 32] = 32'hA4;
        tick();
        tick();
        chk("fair_g1", 64'(cdb_grant), 64'h10);
        chk("fair_r1", 64'(src_ready), 64'h1e);
        tick();
        chk("fair_g2", 64'(cdb_grant), 64'h01);
        chk("fair_r2", 64'(src_ready), 64'h0f);
        tick();
        chk("fair_g3", 64'(cdb_grant), 64'h10);
        chk("fair_c3", 64'(cdb), 64'(word(5'd14, 32'hA4)));
        tick();
        chk("fair_g4", 64'(cdb_grant), 64'h01);
        chk("fair_c4", 64'(cdb), 64'(word(5'd10, 32'hA0)));

        // Backpressure on source 1 while source 0 keeps offering
        do_reset();
        src_valid = 5'b00011;
        src_tag[0 +: 5] = 5'd9; src_data[0 +: 32]  = 32'h90;
        src_tag[5 +: 5] = 5'd3; src_data[32 +: 32] = 32'hA3;
        tick();
        src_tag[5 +: 5] = 5'd4; src_data[32 +: 32] = 32'hA4;
        tick();
        src_valid = 5'b00001;
        chk("bp_ready1", 64'(src_ready[1]), 64'h0);
        chk("bp_g0",     64'(cdb), 64'(word(5'd9, 32'h90)));
        tick();
        chk("bp_tag3",   64'(cdb), 64'(word(5'd3, 32'hA3)));
        chk("bp_g1",     64'(cdb_grant), 64'h02);
        tick();
        chk("bp_g0b",    64'(cdb_grant), 64'h01);
        tick();
        chk("bp_tag4",   64'(cdb), 64'(word(5'd4, 32'hA4)));

        // Tag zero from source 3
        do_reset();
        src_valid = 5'b01000; src_tag[15 +: 5] = 5'd0; src_data[96 +: 32] = 32'h55;
        tick();
        src_valid = 5'b0;
        chk("tz_err", 64'(tag_zero_err), 64'h1);
        tick();
        chk("tz_nocdb",   64'(cdb), 64'h0);
        chk("tz_nogrant", 64'(cdb_grant), 64'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("tz_err_flush", 64'(tag_zero_err), 64'h1);
        do_reset();
        chk("tz_err_rst", 64'(tag_zero_err), 64'h0);

        // Flush with four buffered results; same-cycle push on source 4 dropped
        src_valid = 5'b01111;
        src_tag[0 +: 5] = 5'd1; src_tag[5 +: 5] = 5'd2; src_tag[10 +: 5] = 5'd3; src_tag[15 +: 5] = 5'd4;
        src_tag[20 +: 5] = 5'd5;
        tick();
        src_valid = 5'b10000;
        flush = 1'b1;
        tick();
        src_valid = 5'b0;
        flush = 1'b0;
        chk("fl_cdb",   64'(cdb), 64'h0);
        chk("fl_grant", 64'(cdb_grant), 64'h0);
        chk("fl_ready", 64'(src_ready), 64'h1f);
        tick();
        chk("fl_drop", 64'(cdb), 64'h0);

        // Asynchronous reset in the middle of a broadcast
        src_valid = 5'b01111;
        tick();
        src_valid = 5'b0;
        tick();
        chk("ar_pre", 64'(cdb_grant), 64'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_cdb",   64'(cdb), 64'h0);
        chk("ar_grant", 64'(cdb_grant), 64'h0);
        chk("ar_ready", 64'(src_ready), 64'h1f);
        rst = 1'b0;
        tick();
        tick();
        chk("ar_lost", 64'(cdb), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
